// File: rtl/ha_array_pkg.sv
// Shared constants, FSM state type and the row-weighting rule for the
// half-adder array accumulator.
package ha_array_pkg;

    localparam int N_ARRAYS = 4;
    localparam int T_W      = 9;
    localparam int B_W      = 7;
    localparam int P_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // Array k contributes (t + 4*b) scaled by 4^k; the unshifted sum fits in 10 bits.
    function automatic logic [P_W-1:0] row_value(
        input logic [T_W-1:0] t,
        input logic [B_W-1:0] b,
        input logic [1:0]     k
    );
        logic [P_W-1:0] base;
        base = P_W'(t) + (P_W'(b) << 2);
        return base << {k, 1'b0};
    endfunction

endpackage

// File: rtl/ha_row_weight.sv
// Combinational weighting of one (t, b) row pair into its 16-bit product term.
module ha_row_weight
    import ha_array_pkg::*;
(
    input  logic [T_W-1:0] t,
    input  logic [B_W-1:0] b,
    input  logic [1:0]     k,
    output logic [P_W-1:0] row
);

    assign row = row_value(t, b, k);

endmodule

// File: rtl/ha_array_accumulator.sv
// Captures four weighted row pairs in one handshake and sums them into a
// 16-bit product, ROWS_PER_CYCLE arrays per clock.
module ha_array_accumulator
    import ha_array_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [T_W-1:0] ha_array_0_t,
    input  logic [T_W-1:0] ha_array_1_t,
    input  logic [T_W-1:0] ha_array_2_t,
    input  logic [T_W-1:0] ha_array_3_t,
    input  logic [B_W-1:0] ha_array_0_b,
    input  logic [B_W-1:0] ha_array_1_b,
    input  logic [B_W-1:0] ha_array_2_b,
    input  logic [B_W-1:0] ha_array_3_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] product
);

    state_t         state;
    logic [1:0]     cnt;
    logic [P_W-1:0] acc;
    logic [P_W-1:0] acc_next;
    logic [T_W-1:0] t_in   [N_ARRAYS];
    logic [B_W-1:0] b_in   [N_ARRAYS];
    logic [T_W-1:0] t_hold [N_ARRAYS];
    logic [B_W-1:0] b_hold [N_ARRAYS];
    logic [P_W-1:0] rows   [ROWS_PER_CYCLE];
    logic           accept;
    logic           last_step;

    assign t_in[0] = ha_array_0_t;
    assign t_in[1] = ha_array_1_t;
    assign t_in[2] = ha_array_2_t;
    assign t_in[3] = ha_array_3_t;
    assign b_in[0] = ha_array_0_b;
    assign b_in[1] = ha_array_1_b;
    assign b_in[2] = ha_array_2_b;
    assign b_in[3] = ha_array_3_b;

    // In DONE a new capture may overlap the output handshake on the same edge.
    assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign last_step = (cnt == 2'(N_ARRAYS - ROWS_PER_CYCLE));
    assign product   = acc;

    for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_row
        logic [1:0] idx;
        assign idx = cnt + 2'(g);
        ha_row_weight u_row (
            .t   (t_hold[idx]),
            .b   (b_hold[idx]),
            .k   (idx),
            .row (rows[g])
        );
    end

    always_comb begin
        acc_next = acc;
        for (int g = 0; g < ROWS_PER_CYCLE; g++) begin
            acc_next = acc_next + rows[g];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            for (int k = 0; k < N_ARRAYS; k++) begin
                t_hold[k] <= '0;
                b_hold[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (last_step) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'(ROWS_PER_CYCLE);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? ACC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                acc <= '0;
                cnt <= '0;
                for (int k = 0; k < N_ARRAYS; k++) begin
                    t_hold[k] <= t_in[k];
                    b_hold[k] <= b_in[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Self-checking bench: three accumulators (1, 2 and 4 rows per cycle) checked
// against a plain weighted-sum model with directed and randomized traffic.
module tb_ha_array_accumulator;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       in_valid;
    logic [2:0]       in_ready;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [2:0][15:0] product;
    logic [8:0]       t_in [3][4];
    logic [6:0]       b_in [3][4];

    int total = 0;
    int bad   = 0;
    int exp_q [$];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        ha_array_accumulator #(.ROWS_PER_CYCLE(1 << d)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (in_valid[d]),
            .in_ready     (in_ready[d]),
            .ha_array_0_t (t_in[d][0]),
            .ha_array_1_t (t_in[d][1]),
            .ha_array_2_t (t_in[d][2]),
            .ha_array_3_t (t_in[d][3]),
            .ha_array_0_b (b_in[d][0]),
            .ha_array_1_b (b_in[d][1]),
            .ha_array_2_b (b_in[d][2]),
            .ha_array_3_b (b_in[d][3]),
            .out_valid    (out_valid[d]),
            .out_ready    (out_ready[d]),
            .product      (product[d])
        );
    end

    // Array k is worth (t + 4*b) * 4^k; the total wraps at 2^16.
    function automatic int model(input int d);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (int'(t_in[d][k]) + 4 * int'(b_in[d][k])) * (1 << (2 * k));
        end
        return s % 65536;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int expected);
        total++;
        if (got !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic load_rows(input int d, input logic [3:0][8:0] t, input logic [3:0][6:0] b);
        for (int k = 0; k < 4; k++) begin
            t_in[d][k] = t[k];
            b_in[d][k] = b[k];
        end
    endtask

    task automatic load_random(input int d);
        for (int k = 0; k < 4; k++) begin
            t_in[d][k] = 9'($urandom);
            b_in[d][k] = 7'($urandom);
        end
    endtask

    // Present the current rows of DUT d and return just after the accepting edge.
    task automatic applyStimulus(input int d);
        int guard = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        #1;
        while (!in_ready[d] && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_result(input int d, output int edges);
        edges = 0;
        while (!out_valid[d] && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic drain(input int d);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        checkOutput("drain_valid", int'(out_valid[d]), 0);
    endtask

    task automatic run_case(input int d, input string tag, input int expected);
        int edges;
        applyStimulus(d);
        wait_result(d, edges);
        checkOutput({tag, "_lat"}, edges, 4 >> d);
        checkOutput({tag, "_valid"}, int'(out_valid[d]), 1);
        checkOutput({tag, "_prod"}, int'(product[d]), expected);
        drain(d);
    endtask

    task automatic runRandom(input int d, input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int guard = 0;
                    @(negedge clk);
                    in_valid[d] = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    load_random(d);
                    in_valid[d] = 1'b1;
                    #1;
                    while (!in_ready[d] && guard < 100) begin
                        @(negedge clk);
                        #1;
                        guard++;
                    end
                    if (guard >= 100) checkOutput("rand_accept_timeout", 0, 1);
                    else exp_q.push_back(model(d));
                end
                @(negedge clk);
                in_valid[d] = 1'b0;
            end
            begin
                int          got  = 0;
                int          cyc  = 0;
                bit          held = 1'b0;
                logic [15:0] last_p = '0;
                while (got < n && cyc < n * 40) begin
                    @(negedge clk);
                    cyc++;
                    out_ready[d] = ($urandom_range(0, 3) != 0);
                    #1;
                    if (held) begin
                        checkOutput("hold_valid", int'(out_valid[d]), 1);
                        checkOutput("hold_prod", int'(product[d]), int'(last_p));
                    end
                    held = 1'b0;
                    if (out_valid[d]) begin
                        if (out_ready[d]) begin
                            if (exp_q.size() == 0) checkOutput("spurious_valid", 1, 0);
                            else checkOutput("rand_prod", int'(product[d]), exp_q.pop_front());
                            got++;
                        end else begin
                            held   = 1'b1;
                            last_p = product[d];
                        end
                    end
                end
                if (got < n) checkOutput("rand_timeout", got, n);
                @(negedge clk);
                out_ready[d] = 1'b0;
            end
        join
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        int              edges;
        int              exp_a;

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) load_rows(d, '0, '0);

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset_in_ready", int'(in_ready[d]), 0);
            checkOutput("reset_valid", int'(out_valid[d]), 0);
            checkOutput("reset_prod", int'(product[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("idle_in_ready", int'(in_ready[0]), 1);

        t = '0; b = '0; t[0] = 9'h001;
        load_rows(0, t, b);
        run_case(0, "t0_lsb", 16'h0001);
        t = '0; b = '0; t[1] = 9'h003; b[1] = 7'h01;
        load_rows(0, t, b);
        run_case(0, "arr1", 16'h001C);
        t = '0; b = '0; t[2] = 9'h100;
        load_rows(0, t, b);
        run_case(0, "t2_msb", 16'h1000);
        t = '0; b = '0; b[3] = 7'h40;
        load_rows(0, t, b);
        run_case(0, "b3_msb", 16'h4000);

        t = {4{9'h1FF}};
        b = {4{7'h7F}};
        for (int d = 0; d < 3; d++) begin
            load_rows(d, t, b);
            run_case(d, $sformatf("all_ones_r%0d", 1 << d), 16'h5257);
        end

        load_random(0);
        exp_a = model(0);
        applyStimulus(0);
        wait_result(0, edges);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("stall_valid", int'(out_valid[0]), 1);
            checkOutput("stall_prod", int'(product[0]), exp_a);
            checkOutput("stall_in_ready", int'(in_ready[0]), 0);
        end
        @(negedge clk);
        load_random(0);
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        checkOutput("overlap_in_ready", int'(in_ready[0]), 1);
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        checkOutput("overlap_valid_drop", int'(out_valid[0]), 0);
        wait_result(0, edges);
        checkOutput("overlap_lat", edges, 4);
        checkOutput("overlap_prod", int'(product[0]), model(0));
        drain(0);

        load_random(0);
        applyStimulus(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", int'(in_ready[0]), 0);
        @(posedge clk);
        #1;
        checkOutput("rst_valid", int'(out_valid[0]), 0);
        checkOutput("rst_prod", int'(product[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_random(0);
        applyStimulus(0);
        wait_result(0, edges);
        checkOutput("post_rst_lat", edges, 4);
        checkOutput("post_rst_prod", int'(product[0]), model(0));
        drain(0);

        runRandom(0, 3000);
        runRandom(1, 3000);
        runRandom(2, 4000);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
